// File: rtl/timer_pkg.sv
// Shared types and constants for the dual timer datapath and its register block.
package timer_pkg;

  localparam int unsigned CNT_BW = 32;

  // Control-word bit positions, shared with the AXI4-Lite register block
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_RELOAD_BIT = 1;
  localparam int unsigned CTRL_UP_BIT     = 2;
  localparam int unsigned CTRL_SRC_BIT    = 3;
  localparam int unsigned CTRL_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_e;

  typedef struct packed {
    logic en;
    logic reload;
    logic count_up;
  } cnt_ctrl_t;

  // Decode a register-block control word into per-counter control
  function automatic cnt_ctrl_t ctrl_from_word(input logic [CTRL_W-1:0] word);
    cnt_ctrl_t c;
    c.en       = word[CTRL_EN_BIT];
    c.reload   = word[CTRL_RELOAD_BIT];
    c.count_up = word[CTRL_UP_BIT];
    return c;
  endfunction

  // One count step, wrapping modulo 2^CNT_BW in either direction
  function automatic logic [CNT_BW-1:0] step_value(input logic [CNT_BW-1:0] v,
                                                   input logic              up);
    return up ? CNT_BW'(v + CNT_BW'(1)) : CNT_BW'(v - CNT_BW'(1));
  endfunction

endpackage

// File: rtl/timer_if.sv
// Register-block <-> timer datapath bundle: control/load/compare in, counts/flags out.
interface timer_if;
  import timer_pkg::*;

  logic              i_cnt0_en;
  logic              i_cnt0_reload;
  logic              i_cnt0_count_up;
  logic [CNT_BW-1:0] i_cnt0_load_value;
  logic [CNT_BW-1:0] i_cnt0_compare_value;
  logic              i_cnt1_en;
  logic              i_cnt1_reload;
  logic              i_cnt1_count_up;
  logic              i_cnt1_src;
  logic [CNT_BW-1:0] i_cnt1_load_value;
  logic [CNT_BW-1:0] i_cnt1_compare_value;

  logic [CNT_BW-1:0] o_cnt0_value;
  logic              o_cnt0_match;
  logic              o_cnt0_done;
  logic [CNT_BW-1:0] o_cnt1_value;
  logic              o_cnt1_match;
  logic              o_cnt1_done;
  logic              o_irq;

  // Register block side
  modport master (
    output i_cnt0_en, i_cnt0_reload, i_cnt0_count_up, i_cnt0_load_value, i_cnt0_compare_value,
    output i_cnt1_en, i_cnt1_reload, i_cnt1_count_up, i_cnt1_src, i_cnt1_load_value,
    output i_cnt1_compare_value,
    input  o_cnt0_value, o_cnt0_match, o_cnt0_done,
    input  o_cnt1_value, o_cnt1_match, o_cnt1_done, o_irq
  );

  // Timer datapath side
  modport slave (
    input  i_cnt0_en, i_cnt0_reload, i_cnt0_count_up, i_cnt0_load_value, i_cnt0_compare_value,
    input  i_cnt1_en, i_cnt1_reload, i_cnt1_count_up, i_cnt1_src, i_cnt1_load_value,
    input  i_cnt1_compare_value,
    output o_cnt0_value, o_cnt0_match, o_cnt0_done,
    output o_cnt1_value, o_cnt1_match, o_cnt1_done, o_irq
  );

endinterface

// File: rtl/timer_counter.sv
// One timer channel: IDLE/RUN/DONE control, count value, match pulse and one-shot flag.
module timer_counter
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  cnt_ctrl_t         ctrl_i,
  input  logic [CNT_BW-1:0] load_value_i,
  input  logic [CNT_BW-1:0] compare_value_i,
  input  logic              tick_i,
  output logic [CNT_BW-1:0] value_o,
  output logic              match_o,
  output logic              done_o,
  output logic              match_c_o
);

  cnt_state_e        state_q;
  logic [CNT_BW-1:0] value_q;
  logic              match_q;
  logic              done_q;
  logic              en_q;
  logic              hit_c;

  // Match is only evaluated on a tick while running; load cycles never match
  assign hit_c = (state_q == RUN) && en_q && ctrl_i.en && tick_i &&
                 (value_q == compare_value_i);

  // Next-cycle match, exported so the parent can register irq coincident with match_o
  assign match_c_o = hit_c;

  // Channel state machine with registered value, match and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      match_q <= hit_c;
      if (!ctrl_i.en) begin
        state_q <= IDLE;
        done_q  <= 1'b0;
        en_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            value_q <= load_value_i;
            en_q    <= 1'b1;
            state_q <= RUN;
          end
          RUN: begin
            if (tick_i) begin
              if (value_q == compare_value_i) begin
                if (ctrl_i.reload) begin
                  value_q <= load_value_i;
                end else begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end
              end else begin
                value_q <= step_value(value_q, ctrl_i.count_up);
              end
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign value_o = value_q;
  assign match_o = match_q;
  assign done_o  = done_q;

endmodule

// File: rtl/timer_core.sv
// Dual timer datapath: two channels, counter1 tick source select, combined irq.
module timer_core
  import timer_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  timer_if.slave bus
);

  logic [CTRL_W-1:0] cnt0_word;
  logic [CTRL_W-1:0] cnt1_word;
  cnt_ctrl_t         cnt0_ctrl;
  cnt_ctrl_t         cnt1_ctrl;

  logic [CNT_BW-1:0] cnt0_value;
  logic [CNT_BW-1:0] cnt1_value;
  logic              cnt0_match;
  logic              cnt1_match;
  logic              cnt0_done;
  logic              cnt1_done;
  logic              cnt0_match_c;
  logic              cnt1_match_c;
  logic              cnt1_tick;
  logic              irq_q;

  // Assemble control words in register-block layout and decode them
  always_comb begin
    cnt0_word                  = '0;
    cnt0_word[CTRL_EN_BIT]     = bus.i_cnt0_en;
    cnt0_word[CTRL_RELOAD_BIT] = bus.i_cnt0_reload;
    cnt0_word[CTRL_UP_BIT]     = bus.i_cnt0_count_up;
    cnt1_word                  = '0;
    cnt1_word[CTRL_EN_BIT]     = bus.i_cnt1_en;
    cnt1_word[CTRL_RELOAD_BIT] = bus.i_cnt1_reload;
    cnt1_word[CTRL_UP_BIT]     = bus.i_cnt1_count_up;
    cnt1_word[CTRL_SRC_BIT]    = bus.i_cnt1_src;
  end

  assign cnt0_ctrl = ctrl_from_word(cnt0_word);
  assign cnt1_ctrl = ctrl_from_word(cnt1_word);

  // Cascade mode ticks counter1 on the registered counter0 match pulse
  assign cnt1_tick = cnt1_word[CTRL_SRC_BIT] ? cnt0_match : 1'b1;

  timer_counter u_cnt0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_i          (cnt0_ctrl),
    .load_value_i    (bus.i_cnt0_load_value),
    .compare_value_i (bus.i_cnt0_compare_value),
    .tick_i          (1'b1),
    .value_o         (cnt0_value),
    .match_o         (cnt0_match),
    .done_o          (cnt0_done),
    .match_c_o       (cnt0_match_c)
  );

  timer_counter u_cnt1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_i          (cnt1_ctrl),
    .load_value_i    (bus.i_cnt1_load_value),
    .compare_value_i (bus.i_cnt1_compare_value),
    .tick_i          (cnt1_tick),
    .value_o         (cnt1_value),
    .match_o         (cnt1_match),
    .done_o          (cnt1_done),
    .match_c_o       (cnt1_match_c)
  );

  // irq registered from the next-cycle match terms so it lines up with the match outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= cnt0_match_c | cnt1_match_c;
    end
  end

  assign bus.o_cnt0_value = cnt0_value;
  assign bus.o_cnt0_match = cnt0_match;
  assign bus.o_cnt0_done  = cnt0_done;
  assign bus.o_cnt1_value = cnt1_value;
  assign bus.o_cnt1_match = cnt1_match;
  assign bus.o_cnt1_done  = cnt1_done;
  assign bus.o_irq        = irq_q;

endmodule
